wb_port_arbiter: RTL and testbench

Two-master, one-slave Wishbone B3 classic arbiter that lets the load/store unit's instruction port and data port share a single memory bus. Grants are round-robin between the two ports, held for a whole `cyc` cycle, and guarded by a bus watchdog that synthesizes an error when the slave does not respond. Sits between `load_store_unit` (both master ports) and the memory/interconnect slave.

---
 rtl/wb_port_arbiter_pkg.sv | 39 +++
 rtl/wb_timeout_counter.sv | 39 +++
 rtl/wb_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared bus definitions for the load/store unit's Wishbone arbiter:
// FSM state encodings, grant codes, port identifiers and the default watchdog depth.
package wb_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 64;

  // DRAIN still belongs to the master that timed out, so it keeps reporting that owner.
  function automatic logic [1:0] grant_code(input arb_state_e st, input port_e owner);
    logic [1:0] code;
    case (st)
      ST_GNT_I: code = GRANT_I;
      ST_GNT_D: code = GRANT_D;
      ST_DRAIN: code = (owner == PORT_D) ? GRANT_D : GRANT_I;
      default:  code = GRANT_NONE;
    endcase
    return code;
  endfunction

  function automatic port_e tie_winner(input port_e last);
    return (last == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Bus watchdog: down-counter reloaded on clear, decremented while enabled,
// flags expiry when it reaches terminal count zero.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Loading TIMEOUT-1 makes the zero terminal count land on the TIMEOUT-th enabled cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = LOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin Wishbone B3 classic arbiter letting the LSU instruction and data
// ports share one slave, with a watchdog that synthesizes an error on a silent slave.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [31:0] i_adr_i,
  input  logic [31:0] i_dat_i,
  input  logic [3:0]  i_sel_i,
  input  logic        i_cyc_i,
  input  logic        i_stb_i,
  output logic [31:0] i_dat_o,
  output logic        i_ack_o,
  output logic        i_err_o,

  input  logic [31:0] d_adr_i,
  input  logic [31:0] d_dat_i,
  input  logic [3:0]  d_sel_i,
  input  logic        d_cyc_i,
  input  logic        d_stb_i,
  input  logic        d_we_i,
  output logic [31:0] d_dat_o,
  output logic        d_ack_o,
  output logic        d_err_o,

  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i,

  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  arb_state_e state_q, state_d;
  port_e      last_q, last_d;
  logic [1:0] grant_q, grant_d;

  logic own_i;
  logic own_d;
  logic own_any;
  logic g_cyc;
  logic g_stb;
  logic resp;
  logic wd_clr;
  logic wd_en;
  logic wd_expired;
  logic timeout;

  assign own_i   = (state_q == ST_GNT_I);
  assign own_d   = (state_q == ST_GNT_D);
  assign own_any = own_i | own_d;
  assign g_cyc   = (own_i & i_cyc_i) | (own_d & d_cyc_i);
  assign g_stb   = (own_i & i_stb_i) | (own_d & d_stb_i);
  assign resp    = m_ack_i | m_err_i;

  // Holding clear outside GNT gives a fresh count on every grant entry.
  assign wd_clr  = ~own_any | resp;
  assign wd_en   = g_cyc & g_stb & ~resp;
  assign timeout = wd_en & wd_expired;

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    m_adr_o = '0;
    m_dat_o = '0;
    m_sel_o = '0;
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    if (own_i) begin
      m_adr_o = i_adr_i;
      m_dat_o = i_dat_i;
      m_sel_o = i_sel_i;
      m_cyc_o = i_cyc_i;
      m_stb_o = i_stb_i;
    end else if (own_d) begin
      m_adr_o = d_adr_i;
      m_dat_o = d_dat_i;
      m_sel_o = d_sel_i;
      m_cyc_o = d_cyc_i;
      m_stb_o = d_stb_i;
      m_we_o  = d_we_i;
    end
  end

  // Ack wins over a simultaneous slave error.
  assign i_ack_o   = own_i & m_ack_i;
  assign d_ack_o   = own_d & m_ack_i;
  assign i_err_o   = own_i & ((m_err_i & ~m_ack_i) | timeout);
  assign d_err_o   = own_d & ((m_err_i & ~m_ack_i) | timeout);
  assign timeout_o = timeout;
  assign i_dat_o   = m_dat_i;
  assign d_dat_o   = m_dat_i;
  assign grant_o   = grant_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (i_cyc_i && d_cyc_i) begin
          last_d  = tie_winner(last_q);
          state_d = (last_d == PORT_D) ? ST_GNT_D : ST_GNT_I;
        end else if (d_cyc_i) begin
          last_d  = PORT_D;
          state_d = ST_GNT_D;
        end else if (i_cyc_i) begin
          last_d  = PORT_I;
          state_d = ST_GNT_I;
        end
      end
      ST_GNT_I: begin
        if (!i_cyc_i) begin
          state_d = ST_IDLE;
        end else if (timeout) begin
          state_d = ST_DRAIN;
        end
      end
      ST_GNT_D: begin
        if (!d_cyc_i) begin
          state_d = ST_IDLE;
        end else if (timeout) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!((last_q == PORT_D) ? d_cyc_i : i_cyc_i)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    grant_d = grant_code(state_d, last_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= PORT_I;
      grant_q <= GRANT_NONE;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: scenario tasks plus a response scoreboard.
module tb_wb_port_arbiter;

  localparam int TO = 64;

  logic        clk, rst_n;
  logic [31:0] i_adr_i, i_dat_i, i_dat_o;
  logic [3:0]  i_sel_i;
  logic        i_cyc_i, i_stb_i, i_ack_o, i_err_o;
  logic [31:0] d_adr_i, d_dat_i, d_dat_o;
  logic [3:0]  d_sel_i;
  logic        d_cyc_i, d_stb_i, d_we_i, d_ack_o, d_err_o;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic [3:0]  m_sel_o;
  logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i, m_err_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  typedef struct {
    logic [1:0]  who;
    logic [31:0] dat;
    logic        chk_dat;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  resp_t obs_q[$];
  resp_t obs_r;

  int total = 0;
  int bad   = 0;

  wb_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_adr_i(i_adr_i), .i_dat_i(i_dat_i), .i_sel_i(i_sel_i),
    .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i),
    .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
    .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_sel_i(d_sel_i),
    .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i), .d_we_i(d_we_i),
    .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every response cycle seen by either master is logged for the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (i_ack_o || i_err_o || d_ack_o || d_err_o)) begin
      obs_r.who     = {d_ack_o | d_err_o, i_ack_o | i_err_o};
      obs_r.dat     = (d_ack_o | d_err_o) ? d_dat_o : i_dat_o;
      obs_r.chk_dat = 1'b0;
      obs_r.err     = i_err_o | d_err_o;
      obs_q.push_back(obs_r);
    end
  end

  initial begin
    #1000000;
    $display("FAIL sim_watchdog got=running want=finished");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [1:0] who, input logic [31:0] dat,
                          input logic chk, input logic err);
    resp_t r;
    r.who = who; r.dat = dat; r.chk_dat = chk; r.err = err;
    exp_q.push_back(r);
  endtask

  task automatic idle_inputs;
    i_adr_i = '0; i_dat_i = '0; i_sel_i = '0; i_cyc_i = 0; i_stb_i = 0;
    d_adr_i = '0; d_dat_i = '0; d_sel_i = '0; d_cyc_i = 0; d_stb_i = 0; d_we_i = 0;
    m_dat_i = '0; m_ack_i = 0; m_err_i = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    idle_inputs();
    i_cyc_i = 1; d_cyc_i = 1;
    tick(); smp();
    total++;
    if ({m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o} !== 71'h0) begin
      bad++;
      $display("FAIL reset_bus got=%0h want=0", {m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o});
    end
    total++;
    if ({grant_o, i_ack_o, i_err_o, d_ack_o, d_err_o, timeout_o} !== 7'h0) begin
      bad++;
      $display("FAIL reset_status got=%0h want=0", {grant_o, i_ack_o, i_err_o, d_ack_o, d_err_o, timeout_o});
    end
    i_cyc_i = 0; d_cyc_i = 0;
    tick(); rst_n = 1;
    tick(); tick();
  endtask

  task automatic test_tie_alternation;
    tick(); i_cyc_i = 1; d_cyc_i = 1; smp();
    total++;
    if (grant_o !== 2'b00) begin bad++; $display("FAIL tie1_latency got=%b want=00", grant_o); end
    tick(); smp();
    total++;
    if ({grant_o, m_cyc_o} !== 3'b101) begin bad++; $display("FAIL tie1_data_first got=%b want=101", {grant_o, m_cyc_o}); end
    tick(); d_cyc_i = 0; smp();
    total++;
    if (grant_o !== 2'b10) begin bad++; $display("FAIL tie1_hold got=%b want=10", grant_o); end
    tick(); smp();
    total++;
    if ({grant_o, m_cyc_o} !== 3'b000) begin bad++; $display("FAIL tie1_idle_gap got=%b want=000", {grant_o, m_cyc_o}); end
    tick(); smp();
    total++;
    if (grant_o !== 2'b01) begin bad++; $display("FAIL tie1_instr_next got=%b want=01", grant_o); end
    tick(); i_cyc_i = 0;
    tick(); i_cyc_i = 1; d_cyc_i = 1; smp();
    tick(); smp();
    total++;
    if (grant_o !== 2'b10) begin bad++; $display("FAIL tie2_data got=%b want=10", grant_o); end
    tick(); i_cyc_i = 0; d_cyc_i = 0;
    tick(); i_cyc_i = 1; d_cyc_i = 1; smp();
    total++;
    if (grant_o !== 2'b00) begin bad++; $display("FAIL tie2_idle got=%b want=00", grant_o); end
    tick(); smp();
    total++;
    if (grant_o !== 2'b01) begin bad++; $display("FAIL tie3_instr got=%b want=01", grant_o); end
    tick(); i_cyc_i = 0; d_cyc_i = 0;
    tick(); tick();
  endtask

  task automatic test_single_read;
    tick();
    i_adr_i = 32'h100; i_sel_i = 4'hF; i_cyc_i = 1; i_stb_i = 1;
    smp();
    total++;
    if ({grant_o, m_cyc_o} !== 3'b000) begin bad++; $display("FAIL rd_latency got=%b want=000", {grant_o, m_cyc_o}); end
    tick(); smp();
    total++;
    if ({grant_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o} !== {2'b01, 3'b110, 32'h100}) begin
      bad++; $display("FAIL rd_grant got=%0h want=%0h", {grant_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o}, {2'b01, 3'b110, 32'h100});
    end
    tick(); smp();
    total++;
    if (i_ack_o !== 1'b0) begin bad++; $display("FAIL rd_early_ack got=%b want=0", i_ack_o); end
    tick(); m_ack_i = 1; m_dat_i = 32'h0000_0033;
    push_exp(2'b01, 32'h0000_0033, 1'b1, 1'b0);
    smp();
    total++;
    if ({i_ack_o, d_ack_o, i_dat_o} !== {2'b10, 32'h33}) begin
      bad++; $display("FAIL rd_ack got=%0h want=%0h", {i_ack_o, d_ack_o, i_dat_o}, {2'b10, 32'h33});
    end
    tick(); m_ack_i = 0; m_dat_i = '0; i_cyc_i = 0; i_stb_i = 0; smp();
    total++;
    if ({grant_o, i_ack_o} !== 3'b010) begin bad++; $display("FAIL rd_release got=%b want=010", {grant_o, i_ack_o}); end
    tick(); smp();
    total++;
    if (grant_o !== 2'b00) begin bad++; $display("FAIL rd_idle got=%b want=00", grant_o); end
  endtask

  task automatic test_write_contention;
    tick();
    d_adr_i = 32'h200; d_dat_i = 32'hAB; d_sel_i = 4'h1; d_we_i = 1; d_cyc_i = 1; d_stb_i = 1;
    i_adr_i = 32'h300; i_dat_i = 32'h1234; i_sel_i = 4'hF; i_cyc_i = 1; i_stb_i = 1;
    tick(); m_ack_i = 1;
    push_exp(2'b10, 32'h0, 1'b0, 1'b0);
    smp();
    total++;
    if ({grant_o, m_we_o, m_sel_o, m_dat_o, m_adr_o} !== {2'b10, 1'b1, 4'h1, 32'hAB, 32'h200}) begin
      bad++; $display("FAIL wr_bus got=%0h want=%0h", {grant_o, m_we_o, m_sel_o, m_dat_o, m_adr_o},
                      {2'b10, 1'b1, 4'h1, 32'hAB, 32'h200});
    end
    total++;
    if ({d_ack_o, i_ack_o} !== 2'b10) begin bad++; $display("FAIL wr_ack_route got=%b want=10", {d_ack_o, i_ack_o}); end
    tick(); m_ack_i = 0; d_cyc_i = 0; d_stb_i = 0; d_we_i = 0; smp();
    total++;
    if ({m_stb_o, m_adr_o} !== {1'b0, 32'h200}) begin
      bad++; $display("FAIL wr_no_leak got=%0h want=%0h", {m_stb_o, m_adr_o}, {1'b0, 32'h200});
    end
    tick(); smp();
    total++;
    if ({grant_o, m_stb_o, m_adr_o} !== {3'b000, 32'h0}) begin
      bad++; $display("FAIL wr_idle got=%0h want=0", {grant_o, m_stb_o, m_adr_o});
    end
    tick(); smp();
    total++;
    if ({grant_o, m_stb_o, m_we_o, m_adr_o} !== {2'b01, 2'b10, 32'h300}) begin
      bad++; $display("FAIL wr_instr_after got=%0h want=%0h", {grant_o, m_stb_o, m_we_o, m_adr_o}, {2'b01, 2'b10, 32'h300});
    end
    tick(); m_ack_i = 1; m_dat_i = 32'h5555_AAAA;
    push_exp(2'b01, 32'h5555_AAAA, 1'b1, 1'b0);
    tick(); m_ack_i = 0; m_dat_i = '0; i_cyc_i = 0; i_stb_i = 0;
    tick(); tick();
  endtask

  task automatic test_timeout;
    logic exp_err;
    tick();
    d_adr_i = 32'h400; d_we_i = 0; d_sel_i = 4'hF; d_cyc_i = 1; d_stb_i = 1;
    push_exp(2'b10, 32'h0, 1'b0, 1'b1);
    for (int k = 1; k <= TO; k++) begin
      tick(); smp();
      exp_err = (k == TO);
      total++;
      if ({d_err_o, timeout_o, m_cyc_o} !== {exp_err, exp_err, 1'b1}) begin
        bad++; $display("FAIL wd_cycle_%0d got=%b want=%b", k, {d_err_o, timeout_o, m_cyc_o}, {exp_err, exp_err, 1'b1});
      end
    end
    tick(); m_ack_i = 1; i_cyc_i = 1; smp();
    total++;
    if ({m_cyc_o, m_stb_o, d_ack_o, d_err_o, timeout_o, i_ack_o} !== 6'b0) begin
      bad++; $display("FAIL drain_quiet got=%b want=000000", {m_cyc_o, m_stb_o, d_ack_o, d_err_o, timeout_o, i_ack_o});
    end
    tick(); m_ack_i = 0; d_cyc_i = 0; d_stb_i = 0; smp();
    total++;
    if ({m_cyc_o, m_stb_o} !== 2'b00 || grant_o === 2'b01) begin
      bad++; $display("FAIL drain_hold got=%b want=cyc0_not_instr", {m_cyc_o, m_stb_o, grant_o});
    end
    tick(); smp();
    total++;
    if (grant_o !== 2'b00) begin bad++; $display("FAIL drain_exit got=%b want=00", grant_o); end
    tick(); smp();
    total++;
    if (grant_o !== 2'b01) begin bad++; $display("FAIL drain_next_owner got=%b want=01", grant_o); end
    tick(); i_cyc_i = 0;
    tick(); tick();
  endtask

  task automatic test_ack_err;
    logic exp_err;
    tick();
    i_adr_i = 32'h500; i_sel_i = 4'hF; i_cyc_i = 1; i_stb_i = 1;
    repeat (31) tick();
    m_ack_i = 1; m_err_i = 1; m_dat_i = 32'h77;
    push_exp(2'b01, 32'h77, 1'b1, 1'b0);
    smp();
    total++;
    if ({i_ack_o, i_err_o, timeout_o} !== 3'b100) begin
      bad++; $display("FAIL ackerr_both got=%b want=100", {i_ack_o, i_err_o, timeout_o});
    end
    tick(); m_ack_i = 0; m_err_i = 0; m_dat_i = '0;
    push_exp(2'b01, 32'h0, 1'b0, 1'b1);
    for (int k = 1; k <= TO; k++) begin
      smp();
      exp_err = (k == TO);
      total++;
      if (i_err_o !== exp_err) begin
        bad++; $display("FAIL ackerr_cnt_clear_%0d got=%b want=%b", k, i_err_o, exp_err);
      end
      tick();
    end
    i_cyc_i = 0; i_stb_i = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid;
    tick();
    d_adr_i = 32'h600; d_cyc_i = 1; d_stb_i = 1;
    tick(); smp();
    total++;
    if ({grant_o, m_cyc_o} !== 3'b101) begin bad++; $display("FAIL mid_pre got=%b want=101", {grant_o, m_cyc_o}); end
    tick(); #1;
    rst_n = 0; m_ack_i = 1;
    #1;
    total++;
    if ({m_cyc_o, m_stb_o, grant_o, d_ack_o} !== 5'b0) begin
      bad++; $display("FAIL mid_async got=%b want=00000", {m_cyc_o, m_stb_o, grant_o, d_ack_o});
    end
    tick(); m_ack_i = 0; d_cyc_i = 0; d_stb_i = 0;
    tick(); rst_n = 1;
    tick(); i_cyc_i = 1; d_cyc_i = 1;
    tick(); smp();
    total++;
    if (grant_o !== 2'b10) begin bad++; $display("FAIL post_reset_tie got=%b want=10", grant_o); end
    tick(); i_cyc_i = 0; d_cyc_i = 0;
    tick(); tick();
  endtask

  task automatic test_scoreboard;
    resp_t e, o;
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL sb_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o.who !== e.who || o.err !== e.err || (e.chk_dat && o.dat !== e.dat)) begin
        bad++; $display("FAIL sb_resp got=who%b err%b dat%h want=who%b err%b dat%h",
                        o.who, o.err, o.dat, e.who, e.err, e.dat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tie_alternation();
    test_single_read();
    test_write_contention();
    test_timeout();
    test_ack_err();
    test_reset_mid();
    test_scoreboard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
